// File: rtl/linebuffer_kxk_stream.sv
// -----------------------------------------------------------------------------
// linebuffer_kxk_stream
//
// Sliding-window generator for the convolution datapath. Takes a raster-order
// pixel stream and produces every KxK window that fits completely inside the
// image ("valid" convolution), tagged with the window's output-map row and
// column. Sits between the ifmap fetch stream and the PE array.
//
// Storage:
//   - K-1 chained row buffers, IMG_W entries each. Each one acts as a delay
//     line of exactly one image row, addressed by the current column counter:
//     the entry read at column c is the pixel from the same column one row up,
//     and the same entry is overwritten with the pixel moving down into it.
//   - A KxK window register array that shifts left one column per accepted
//     pixel, loading the new rightmost column from the row-buffer outputs.
//
// Window layout: element r*K+c (r = 0 oldest row, c = 0 oldest column) holds
// pixel (row-(K-1)+r, col-(K-1)+c). Element K*K-1 is the pixel just accepted.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   in_valid   in_data carries a pixel
//   in_ready   block can accept a pixel this cycle (= ~win_valid | win_ready)
//   in_data    raster-order pixel, DW bits
//   win_valid  win_data/win_row/win_col hold a complete window
//   win_ready  consumer takes the window this cycle
//   win_data   packed KxK window, element 0 = top-left
//   win_row    output-map row of the window (top row of the window)
//   win_col    output-map column of the window (left column of the window)
//   frame_done one-cycle pulse the cycle after the last pixel of a frame
// -----------------------------------------------------------------------------
module linebuffer_kxk_stream #(
  parameter  int DW    = 16,
  parameter  int K     = 3,
  parameter  int IMG_W = 8,
  parameter  int IMG_H = 8,
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [K*K-1:0][DW-1:0]   win_data,
  output logic [RW-1:0]            win_row,
  output logic [CW-1:0]            win_col,
  output logic                     frame_done
);

  // Counter limits, sized to the counters so every comparison is width-exact.
  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(K - 1);

  logic                   accept;
  logic                   emit;
  logic                   col_wrap;
  logic                   last_pixel;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;

  // rb_out[i] is the pixel i+1 rows above the incoming one, same column.
  logic [K-2:0][DW-1:0]   rb_out;
  // Incoming window column, index 0 = oldest row, K-1 = in_data.
  logic [K-1:0][DW-1:0]   new_col;
  logic [K*K-1:0][DW-1:0] win_next;

  // ---------------------------------------------------------------------------
  // Handshake. in_ready looks only at our own output register and the
  // consumer's ready, so there is no combinational path from in_valid.
  // ---------------------------------------------------------------------------
  assign in_ready   = ~win_valid | win_ready;
  assign accept     = in_valid & in_ready;

  assign col_wrap   = (col == COL_LAST);
  assign last_pixel = col_wrap & (row == ROW_LAST);

  // A window is complete once the accepted pixel is at least K-1 rows and
  // K-1 columns into the frame; this also keeps rows and frames from mixing,
  // because stale row-buffer contents only ever feed windows that fail it.
  assign emit = accept & (row >= ROW_FIRST_WIN) & (col >= COL_FIRST_WIN);

  // ---------------------------------------------------------------------------
  // Raster position of the pixel currently being offered.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking (<=) so every always_ff reads the
  // pre-edge values of the others regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Row buffers. Because the column counter wraps every IMG_W accepts, using
  // it as the address turns a plain array into a one-row delay line without a
  // separate pointer.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < K - 1; i++) begin : g_rowbuf
    logic [DW-1:0] mem [IMG_W];
    logic [DW-1:0] feed;

    if (i == 0) begin : g_head
      assign feed = in_data;
    end else begin : g_chain
      assign feed = rb_out[i-1];
    end

    assign rb_out[i] = mem[col];

    // NOTE: the row storage has no reset on purpose; it is a RAM, and its
    // contents are never observed before a full set of fresh rows is written.
    always_ff @(posedge clk) begin
      if (accept) begin
        mem[col] <= feed;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next window: shift every row left one column, append the new column.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    new_col        = '0;
    new_col[K-1]   = in_data;
    for (int r = 0; r < K - 1; r++) begin
      new_col[r] = rb_out[K-2-r];
    end
  end

  always_comb begin
    win_next = win_data;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_next[r*K+c] = win_data[r*K+c+1];
      end
      win_next[r*K+K-1] = new_col[r];
    end
  end

  // ---------------------------------------------------------------------------
  // Window register and output qualifiers. While a window waits for the
  // consumer, in_ready is low, nothing is accepted and everything here holds.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      win_data   <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept & last_pixel;
      if (accept) begin
        win_data  <= win_next;
        // An accept implies the previous window (if any) was consumed, so
        // win_valid simply follows whether this pixel completes a window.
        win_valid <= emit;
        if (emit) begin
          win_row <= row - ROW_FIRST_WIN;
          win_col <= col - COL_FIRST_WIN;
        end
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_linebuffer_kxk_stream.sv
// -----------------------------------------------------------------------------
// Testbench for linebuffer_kxk_stream.
// Two instances: A (K=3, 4x4) and B (K=5, 7x6). Each has a frame model that
// records every accepted pixel at its raster position and, whenever a pixel
// completes a window, builds the expected window straight from the image.
// A negedge compare process checks each DUT against its model every cycle;
// hand-computed literal windows and coordinates pin the model itself.
// -----------------------------------------------------------------------------
module tb_linebuffer_kxk_stream;

  localparam int DW = 16;
  localparam int KA = 3, WA = 4, HA = 4;
  localparam int KB = 5, WB = 7, HB = 6;

  typedef logic [KA*KA-1:0][DW-1:0] win_a_t;
  typedef logic [KB*KB-1:0][DW-1:0] win_b_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A signals
  logic          rst_a, in_valid_a, in_ready_a, win_valid_a, win_ready_a, frame_done_a;
  logic [DW-1:0] in_data_a;
  win_a_t        win_data_a;
  logic [1:0]    win_row_a, win_col_a;

  // DUT B signals
  logic          rst_b, in_valid_b, in_ready_b, win_valid_b, win_ready_b, frame_done_b;
  logic [DW-1:0] in_data_b;
  win_b_t        win_data_b;
  logic [2:0]    win_row_b, win_col_b;

  linebuffer_kxk_stream #(.DW(DW), .K(KA), .IMG_W(WA), .IMG_H(HA)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .win_valid(win_valid_a), .win_ready(win_ready_a),
    .win_data(win_data_a), .win_row(win_row_a), .win_col(win_col_a),
    .frame_done(frame_done_a)
  );

  linebuffer_kxk_stream #(.DW(DW), .K(KB), .IMG_W(WB), .IMG_H(HB)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .win_valid(win_valid_b), .win_ready(win_ready_b),
    .win_data(win_data_b), .win_row(win_row_b), .win_col(win_col_b),
    .frame_done(frame_done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame models and captured (consumed) windows
  // ---------------------------------------------------------------------------
  int     img_a [WA*HA];
  int     mr_a = 0, mc_a = 0;
  bit     ea_valid = 0, ea_fd = 0, chk_rst_a = 0;
  int     ea_row = 0, ea_col = 0;
  int     ea_data [KA*KA];
  win_a_t cap_a [$];
  int     cap_row_a [$], cap_col_a [$];
  int     fd_cnt_a = 0, fd_valid_a = 0, fd_row_a = 0, fd_col_a = 0;
  int     stall_cnt_a = 0;

  int     img_b [WB*HB];
  int     mr_b = 0, mc_b = 0;
  bit     eb_valid = 0, eb_fd = 0;
  int     eb_row = 0, eb_col = 0;
  int     eb_data [KB*KB];
  win_b_t cap_b [$];
  int     cap_row_b [$], cap_col_b [$];

  always @(negedge clk) begin : mon_a
    bit acc;
    if (chk_rst_a) begin
      for (int e = 0; e < KA*KA; e++) check("a_rst_data", win_data_a[e], 0);
      check("a_rst_row", win_row_a, 0);
      check("a_rst_col", win_col_a, 0);
      check("a_rst_in_ready", in_ready_a, 1);
      chk_rst_a = 0;
    end
    check("a_win_valid", win_valid_a, ea_valid);
    if (ea_valid) begin
      for (int e = 0; e < KA*KA; e++) check("a_win_data", win_data_a[e], ea_data[e]);
      check("a_win_row", win_row_a, ea_row);
      check("a_win_col", win_col_a, ea_col);
    end
    check("a_frame_done", frame_done_a, ea_fd);
    check("a_in_ready", in_ready_a, !ea_valid || win_ready_a);
    if (frame_done_a) begin
      fd_cnt_a++; fd_valid_a = win_valid_a; fd_row_a = win_row_a; fd_col_a = win_col_a;
    end
    if (win_valid_a && win_ready_a) begin
      cap_a.push_back(win_data_a); cap_row_a.push_back(win_row_a); cap_col_a.push_back(win_col_a);
    end
    if (!in_ready_a) stall_cnt_a++;
    // Advance the model to what the outputs must be after the next edge.
    acc   = in_valid_a && (!ea_valid || win_ready_a);
    ea_fd = 0;
    if (rst_a) begin
      mr_a = 0; mc_a = 0; ea_valid = 0; chk_rst_a = 1;
    end else if (acc) begin
      img_a[mr_a*WA+mc_a] = in_data_a;
      ea_fd = (mr_a == HA-1) && (mc_a == WA-1);
      if (mr_a >= KA-1 && mc_a >= KA-1) begin
        ea_valid = 1; ea_row = mr_a-(KA-1); ea_col = mc_a-(KA-1);
        for (int e = 0; e < KA*KA; e++)
          ea_data[e] = img_a[(ea_row + e/KA)*WA + ea_col + e%KA];
      end else begin
        ea_valid = 0;
      end
      mc_a = (mc_a + 1) % WA;
      if (mc_a == 0) mr_a = (mr_a + 1) % HA;
    end else if (win_ready_a) begin
      ea_valid = 0;
    end
  end

  always @(negedge clk) begin : mon_b
    bit acc;
    check("b_win_valid", win_valid_b, eb_valid);
    if (eb_valid) begin
      for (int e = 0; e < KB*KB; e++) check("b_win_data", win_data_b[e], eb_data[e]);
      check("b_win_row", win_row_b, eb_row);
      check("b_win_col", win_col_b, eb_col);
    end
    check("b_frame_done", frame_done_b, eb_fd);
    check("b_in_ready", in_ready_b, !eb_valid || win_ready_b);
    if (win_valid_b && win_ready_b) begin
      cap_b.push_back(win_data_b); cap_row_b.push_back(win_row_b); cap_col_b.push_back(win_col_b);
    end
    acc   = in_valid_b && (!eb_valid || win_ready_b);
    eb_fd = 0;
    if (rst_b) begin
      mr_b = 0; mc_b = 0; eb_valid = 0;
    end else if (acc) begin
      img_b[mr_b*WB+mc_b] = in_data_b;
      eb_fd = (mr_b == HB-1) && (mc_b == WB-1);
      if (mr_b >= KB-1 && mc_b >= KB-1) begin
        eb_valid = 1; eb_row = mr_b-(KB-1); eb_col = mc_b-(KB-1);
        for (int e = 0; e < KB*KB; e++)
          eb_data[e] = img_b[(eb_row + e/KB)*WB + eb_col + e%KB];
      end else begin
        eb_valid = 0;
      end
      mc_b = (mc_b + 1) % WB;
      if (mc_b == 0) mr_b = (mr_b + 1) % HB;
    end else if (win_ready_b) begin
      eb_valid = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Consumer for A: 0 = always ready, 1 = random, 2 = stall 5 cycles on the
  // first window seen.
  // ---------------------------------------------------------------------------
  int ready_mode = 0;
  bit stall_used = 0;
  int stall_left = 0;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 2 && !stall_used && win_valid_a) begin
      stall_left = 5; stall_used = 1;
    end
    if (stall_left > 0) begin
      win_ready_a = 1'b0; stall_left--;
    end else if (ready_mode == 1) begin
      win_ready_a = 1'($urandom_range(0, 1));
    end else begin
      win_ready_a = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers (called at posedge+1, return at posedge+1 after the accept)
  // ---------------------------------------------------------------------------
  task automatic send_a(input int d, input int gap_pct);
    bit got;
    int budget;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      in_valid_a = 1'b0; @(posedge clk); #1;
    end
    in_valid_a = 1'b1; in_data_a = DW'(d);
    budget = 0;
    do begin
      @(negedge clk); got = in_ready_a;
      @(posedge clk); #1;
      budget++;
    end while (!got && budget < 200);
    if (!got) begin checks++; errors++; $display("FAIL a_accept_timeout: pixel %0d never accepted", d); end
  endtask

  task automatic send_b(input int d);
    bit got;
    int budget;
    in_valid_b = 1'b1; in_data_b = DW'(d);
    budget = 0;
    do begin
      @(negedge clk); got = in_ready_b;
      @(posedge clk); #1;
      budget++;
    end while (!got && budget < 200);
    if (!got) begin checks++; errors++; $display("FAIL b_accept_timeout: pixel %0d never accepted", d); end
  endtask

  task automatic idle(input int n);
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    cap_a.delete(); cap_row_a.delete(); cap_col_a.delete();
    fd_cnt_a = 0; fd_valid_a = 0; fd_row_a = 0; fd_col_a = 0; stall_cnt_a = 0;
  endtask

  // Hand-computed windows of a 4x4 ramp frame, K=3.
  int first_lit [KA*KA] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int last_lit  [KA*KA] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

  task automatic check_frame_a(input string tag, input int idx, input int offset);
    if (cap_a.size() >= idx + 4) begin
      for (int e = 0; e < KA*KA; e++) begin
        check({tag, "_first_data"}, cap_a[idx][e], first_lit[e] + offset);
        check({tag, "_last_data"},  cap_a[idx+3][e], last_lit[e] + offset);
      end
      check({tag, "_first_row"}, cap_row_a[idx], 0);
      check({tag, "_first_col"}, cap_col_a[idx], 0);
      check({tag, "_last_row"},  cap_row_a[idx+3], 1);
      check({tag, "_last_col"},  cap_col_a[idx+3], 1);
    end
  endtask

  // Expected coordinates for B (K=5, 7x6): 2 rows x 3 columns of windows.
  int b_row_lit [6] = '{0, 0, 0, 1, 1, 1};
  int b_col_lit [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_data_a = '0; in_data_b = '0;
    win_ready_a = 1'b1; win_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // 1: ramp, always ready
    clear_a();
    for (int p = 0; p < 16; p++) send_a(p, 0);
    idle(4);
    check("s1_count", cap_a.size(), 4);
    check_frame_a("s1", 0, 0);
    check("s1_fd_count", fd_cnt_a, 1);
    check("s1_fd_with_window", fd_valid_a, 1);
    check("s1_fd_row", fd_row_a, 1);
    check("s1_fd_col", fd_col_a, 1);

    // 2: consumer stalls 5 cycles on the first window
    clear_a(); ready_mode = 2; stall_used = 0;
    for (int p = 0; p < 16; p++) send_a(p, 0);
    idle(4);
    ready_mode = 0;
    check("s2_count", cap_a.size(), 4);
    check("s2_stall_cycles", stall_cnt_a, 5);
    check_frame_a("s2", 0, 0);

    // 3: random input gaps and random consumer, two frames
    clear_a(); ready_mode = 1;
    for (int p = 0; p < 32; p++) send_a(p % 16, 50);
    ready_mode = 0;
    idle(6);
    check("s3_count", cap_a.size(), 8);
    check_frame_a("s3a", 0, 0);
    check_frame_a("s3b", 4, 0);

    // 4: back-to-back frames with different data
    clear_a();
    for (int p = 0; p < 16; p++) send_a(p, 0);
    for (int p = 0; p < 16; p++) send_a(100 + p, 0);
    idle(4);
    check("s4_count", cap_a.size(), 8);
    check_frame_a("s4a", 0, 0);
    check_frame_a("s4b", 4, 100);
    check("s4_fd_count", fd_cnt_a, 2);

    // 5: reset mid-frame after pixel 7, then restart
    clear_a();
    for (int p = 0; p < 8; p++) send_a(p, 0);
    in_valid_a = 1'b0; rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    check("s5_pre_count", cap_a.size(), 0);
    for (int p = 0; p < 16; p++) send_a(p, 0);
    idle(4);
    check("s5_count", cap_a.size(), 4);
    check_frame_a("s5", 0, 0);

    // 6: K=5 on a 7x6 frame
    for (int p = 0; p < 42; p++) send_b(p);
    idle(4);
    check("s6_count", cap_b.size(), 6);
    if (cap_b.size() == 6) begin
      for (int e = 0; e < KB*KB; e++)
        check("s6_first_data", cap_b[0][e], (e / KB) * WB + (e % KB));
      check("s6_first_elem24", cap_b[0][24], 32);
      for (int i = 0; i < 6; i++) begin
        check("s6_row", cap_row_b[i], b_row_lit[i]);
        check("s6_col", cap_col_b[i], b_col_lit[i]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
